multi_data_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one variable-latency multi-data unit between NUM_REQ requesters.
- The unit has a start/in/done/out interface and no busy or ready signal. Its result is valid only during the single done cycle.
- This block serialises requests, issues exactly one start per job, and captures out on done. It returns a tagged response, and a watchdog recovers the unit if done never arrives.

---
 rtl/multi_data_arbiter.sv | 126 ++++++++++++
 tb/tb_multi_data_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_data_arbiter.sv
// Round-robin front end that shares one start/done multi-data unit between
// NUM_REQ requesters, with a watchdog that flushes the unit when done never comes.
module multi_data_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic                      unit_start,
    output logic [DATA_W-1:0]         unit_in,
    output logic                      unit_reset,
    input  logic                      unit_done,
    input  logic [DATA_W-1:0]         unit_out,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FLUSH, RESP} state_t;

    state_t                           state, state_nxt;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_vec;
    logic [PTR_W-1:0]                 ptr, gnt_idx, idx, id_q;
    logic [NUM_REQ-1:0]               gnt;
    logic                             found, accept;
    logic [CNT_W-1:0]                 wait_cnt;

    assign req_vec = req_data;

    // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(ptr) + k >= NUM_REQ)
                idx = PTR_W'(int'(ptr) + k - NUM_REQ);
            else
                idx = PTR_W'(int'(ptr) + k);
            if (!found && req_valid[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    assign accept     = (state == IDLE) && found;
    assign req_ready  = (state == IDLE) ? gnt : '0;
    assign unit_start = (state == ISSUE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign resp_id    = ID_W'(id_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                // A done in the last allowed cycle still beats the watchdog.
                if (unit_done)                 state_nxt = RESP;
                else if (wait_cnt == CNT_LAST) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            id_q       <= '0;
            unit_in    <= '0;
            wait_cnt   <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            unit_reset <= 1'b1;
        end else begin
            // Registered so the unit sees a clean full-cycle reset during FLUSH.
            unit_reset <= (state_nxt == FLUSH);
            case (state)
                IDLE: if (accept) begin
                    unit_in <= req_vec[gnt_idx];
                    id_q    <= gnt_idx;
                    ptr     <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (unit_done) begin
                        resp_data <= unit_out;
                        resp_err  <= 1'b0;
                    end else if (wait_cnt != CNT_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    resp_data <= '0;
                    resp_err  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_data_arbiter.sv
// Directed bench: a behavioural unit model drives done/out, a scoreboard queue
// holds expected responses and is checked on every response handshake.
module tb_multi_data_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              resp_valid, resp_ready;
    logic [1:0]        resp_id;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic              unit_start, unit_reset, unit_done, busy;
    logic [DW-1:0]     unit_in, unit_out;

    logic              model_en, model_done, man_done;
    logic [DW-1:0]     model_out, man_out, model_mask, m_op;
    int                model_delay, m_d;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0, starts = 0;
    int n, b, cyc, w, s0;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [1:0]    hid;
    logic [DW-1:0] hdata;

    multi_data_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(2), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .unit_start(unit_start), .unit_in(unit_in), .unit_reset(unit_reset),
        .unit_done(unit_done), .unit_out(unit_out), .busy(busy)
    );

    always #5 clock = ~clock;

    assign unit_done = model_done | man_done;
    assign unit_out  = model_done ? model_out : man_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int id, input logic [DW-1:0] d, input logic e);
        exp_t t;
        t.id = 2'(id);
        t.data = d;
        t.err = e;
        sb.push_back(t);
    endtask

    task automatic drain(input string tag);
        int bb = 0;
        @(negedge clock);
        while ((sb.size() != 0 || busy) && bb < 300) begin
            @(negedge clock);
            bb++;
        end
        chk(tag, {63'd0, (sb.size() == 0 && !busy)}, 64'd1);
    endtask

    // Unit model: done pulses d cycles after the first WAIT cycle.
    always begin
        @(negedge clock);
        if (model_en && unit_start && !reset) begin
            m_op = unit_in;
            m_d  = model_delay;
            repeat (m_d + 1) @(posedge clock);
            #1;
            model_done = 1'b1;
            model_out  = m_op ^ model_mask;
            @(posedge clock);
            #1;
            model_done = 1'b0;
        end
    end

    always @(negedge clock) if (unit_start) starts++;

    // Scoreboard side: every accepted response must match the next expectation.
    always @(negedge clock) begin
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e.id));
                chk("resp_data", 64'(resp_data), 64'(e.data));
                chk("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b1;
        model_en = 1'b1; model_done = 1'b0; man_done = 1'b0;
        model_out = '0; man_out = '0; model_mask = '0; model_delay = 2;

        // Reset state
        repeat (2) tick();
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_unit_reset", 64'(unit_reset), 64'd1);
        chk("rst_unit_start", 64'(unit_start), 64'd0);
        chk("rst_unit_in", 64'(unit_in), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);

        // Single requester, delay 2, response 7 cycles after release
        tick(); reset = 1'b0;
        @(negedge clock); chk("t1_ureset_hold", 64'(unit_reset), 64'd1);
        tick();
        @(negedge clock); chk("t1_ureset_drop", 64'(unit_reset), 64'd0);
        tick();
        req_valid = 4'b0010; req_data[1*DW +: DW] = 32'h0000_0012;
        push(1, 32'h0000_0012, 1'b0);
        @(negedge clock); chk("t1_grant", 64'(req_ready), 64'b0010);
        tick(); req_valid = '0;
        @(negedge clock);
        chk("t1_start", 64'(unit_start), 64'd1);
        chk("t1_unit_in", 64'(unit_in), 64'h12);
        cyc = 3;
        while (!resp_valid && cyc < 30) begin
            tick(); cyc++;
            @(negedge clock);
        end
        chk("t1_latency", 64'(cyc), 64'd7);
        drain("t1_drain");

        // Fresh pointer, all four requesters continuously valid
        model_mask = 32'hA5A5_0000; model_delay = 1;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h100 + i;
        for (int i = 0; i < 5; i++) push(order[i], (32'h100 + order[i]) ^ model_mask, 1'b0);
        s0 = starts;
        req_valid = 4'b1111;
        n = 0; b = 0;
        while (n < 5 && b < 200) begin
            @(negedge clock);
            if (|(req_valid & req_ready)) begin
                chk("t2_grant_order", 64'(req_ready), 64'd1 << order[n]);
                n++;
            end
            tick(); b++;
        end
        req_valid = '0;
        chk("t2_grants_seen", 64'(n), 64'd5);
        drain("t2_drain");
        chk("t2_start_count", 64'(starts - s0), 64'd5);

        // Back-pressure: response held for 10 cycles, requester 0 waits
        tick();
        resp_ready = 1'b0;
        req_valid = 4'b1000; req_data[3*DW +: DW] = 32'h3333_0003;
        push(3, 32'h3333_0003 ^ model_mask, 1'b0);
        @(negedge clock); chk("t3_grant", 64'(req_ready), 64'b1000);
        tick();
        req_valid = 4'b0001; req_data[0 +: DW] = 32'h0000_00A0;
        push(0, 32'h0000_00A0 ^ model_mask, 1'b0);
        b = 0;
        @(negedge clock);
        while (!resp_valid && b < 30) begin
            @(negedge clock); b++;
        end
        chk("t3_resp_seen", 64'(resp_valid), 64'd1);
        hid = resp_id; hdata = resp_data;
        chk("t3_resp_data", 64'(hdata), 64'(32'h3333_0003 ^ model_mask));
        s0 = starts;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clock);
            chk("t3_hold_valid", 64'(resp_valid), 64'd1);
            chk("t3_hold_id", 64'(resp_id), 64'(hid));
            chk("t3_hold_data", 64'(resp_data), 64'(hdata));
            chk("t3_hold_ready", 64'(req_ready), 64'd0);
        end
        chk("t3_no_start", 64'(starts - s0), 64'd0);
        tick(); resp_ready = 1'b1;
        @(negedge clock); chk("t3_handshake", 64'(resp_valid), 64'd1);
        tick();
        @(negedge clock);
        chk("t3_released", 64'(resp_valid), 64'd0);
        chk("t3_next_grant", 64'(req_ready), 64'b0001);
        tick(); req_valid = '0;
        drain("t3_drain");

        // Watchdog: no done, 8 WAIT cycles, one FLUSH, error response
        model_en = 1'b0;
        tick();
        resp_ready = 1'b0;
        req_valid = 4'b0100; req_data[2*DW +: DW] = 32'h4444_0004;
        push(2, 32'h0, 1'b1);
        @(negedge clock); chk("t4_grant", 64'(req_ready), 64'b0100);
        tick(); req_valid = '0;
        @(negedge clock); chk("t4_start", 64'(unit_start), 64'd1);
        w = 0;
        tick();
        @(negedge clock);
        while (!unit_reset && busy && w < 20) begin
            w++;
            tick();
            @(negedge clock);
        end
        chk("t4_wait_cycles", 64'(w), 64'd8);
        chk("t4_flush", 64'(unit_reset), 64'd1);
        chk("t4_flush_no_resp", 64'(resp_valid), 64'd0);
        tick();
        @(negedge clock);
        chk("t4_resp_valid", 64'(resp_valid), 64'd1);
        chk("t4_flush_one", 64'(unit_reset), 64'd0);
        chk("t4_resp_err", 64'(resp_err), 64'd1);
        chk("t4_resp_data", 64'(resp_data), 64'd0);
        tick(); tick();
        man_done = 1'b1; man_out = 32'hDEAD_BEEF;
        tick(); man_done = 1'b0;
        @(negedge clock);
        chk("t4_late_done_data", 64'(resp_data), 64'd0);
        chk("t4_late_done_err", 64'(resp_err), 64'd1);
        chk("t4_late_done_valid", 64'(resp_valid), 64'd1);
        tick(); resp_ready = 1'b1;
        drain("t4_drain");

        // Done arrives in the last WAIT cycle: normal response, no FLUSH
        tick();
        req_valid = 4'b0010; req_data[1*DW +: DW] = 32'h5555_0005;
        @(negedge clock); chk("t5_grant", 64'(req_ready), 64'b0010);
        tick(); req_valid = '0;
        @(negedge clock); chk("t5_start", 64'(unit_start), 64'd1);
        tick();
        repeat (7) tick();
        man_done = 1'b1; man_out = 32'h7777_0007;
        push(1, 32'h7777_0007, 1'b0);
        @(negedge clock); chk("t5_no_flush_last", 64'(unit_reset), 64'd0);
        tick(); man_done = 1'b0;
        @(negedge clock);
        chk("t5_resp_valid", 64'(resp_valid), 64'd1);
        chk("t5_no_flush", 64'(unit_reset), 64'd0);
        drain("t5_drain");

        // Asynchronous reset during WAIT, then pointer restarts at 0
        tick();
        req_valid = 4'b0100; req_data[2*DW +: DW] = 32'h6666_0006;
        @(negedge clock); chk("t6_grant", 64'(req_ready), 64'b0100);
        tick(); req_valid = '0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_resp_valid", 64'(resp_valid), 64'd0);
        chk("t6_unit_reset", 64'(unit_reset), 64'd1);
        chk("t6_unit_start", 64'(unit_start), 64'd0);
        chk("t6_unit_in", 64'(unit_in), 64'd0);
        chk("t6_resp_id", 64'(resp_id), 64'd0);
        chk("t6_resp_data", 64'(resp_data), 64'd0);
        chk("t6_resp_err", 64'(resp_err), 64'd0);
        tick(); tick();
        reset = 1'b0; model_en = 1'b1;
        req_valid = 4'b1100;
        req_data[2*DW +: DW] = 32'h0000_2222; req_data[3*DW +: DW] = 32'h0000_3333;
        push(2, 32'h0000_2222 ^ model_mask, 1'b0);
        @(negedge clock);
        chk("t6_rr_restart", 64'(req_ready), 64'b0100);
        chk("t6_ureset_hold", 64'(unit_reset), 64'd1);
        tick(); req_valid = '0;
        drain("t6_drain");

        repeat (4) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
